// File: rtl/imem_fetch.sv
// Instruction fetch front-end: one outstanding req/ack read, registered ins with valid/ready.
// Optional watchdog on mem_ack enabled by defining FETCH_TIMEOUT_EN.
module imem_fetch #(
    parameter int REG_WIDTH   = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] pc,
    input  logic                 fetch_req,
    input  logic                 flush,
    output logic                 mem_req,
    output logic [REG_WIDTH-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [REG_WIDTH-1:0] mem_rdata,
    output logic [REG_WIDTH-1:0] ins,
    output logic                 ins_valid,
    input  logic                 ins_ready,
    output logic                 stall,
    output logic                 fetch_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    state_t               state_q;
    logic                 mem_req_q;
    logic [REG_WIDTH-1:0] mem_addr_q;
    logic [REG_WIDTH-1:0] ins_q;
    logic                 ins_valid_q;
    logic                 drop_q;
    logic                 fetch_err_q;
    logic                 start_ok;

`ifdef FETCH_TIMEOUT_EN
    localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WDW-1:0] wdog_q;
    logic           tmo;
    assign tmo = (wdog_q == WDW'(TIMEOUT_CYC - 1));
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = TIMEOUT_CYC;
`endif

    // A timed-out fetch path refuses new work until reset
    assign start_ok = fetch_req & ~fetch_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            ins_q       <= '0;
            ins_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            fetch_err_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wdog_q      <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_ok && !flush) begin
                        mem_addr_q <= pc;
                        mem_req_q  <= 1'b1;
                        state_q    <= REQ;
`ifdef FETCH_TIMEOUT_EN
                        wdog_q     <= '0;
`endif
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (drop_q || flush) begin
                            drop_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            ins_q       <= mem_rdata;
                            ins_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tmo) begin
                        fetch_err_q <= 1'b1;
                        mem_req_q   <= 1'b0;
                        drop_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        if (flush) drop_q <= 1'b1;
                        wdog_q <= wdog_q + 1'b1;
                    end
`else
                    else if (flush) begin
                        drop_q <= 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (flush) begin
                        ins_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (ins_ready) begin
                        ins_valid_q <= 1'b0;
                        if (start_ok) begin
                            mem_addr_q <= pc;
                            mem_req_q  <= 1'b1;
                            state_q    <= REQ;
`ifdef FETCH_TIMEOUT_EN
                            wdog_q     <= '0;
`endif
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign ins       = ins_q;
    assign ins_valid = ins_valid_q;
    assign stall     = ~ins_valid_q | drop_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Directed table-driven bench for imem_fetch plus hand sequences for reset and watchdog.
module tb_imem_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic        fetch_req;
    logic        flush;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ins;
    logic        ins_valid;
    logic        ins_ready;
    logic        stall;
    logic        fetch_err;

    int n_vec;
    int n_bad;

    imem_fetch #(
        .REG_WIDTH  (16),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .fetch_req(fetch_req),
        .flush    (flush),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .ins      (ins),
        .ins_valid(ins_valid),
        .ins_ready(ins_ready),
        .stall    (stall),
        .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        fr;
        logic        fl;
        logic        ack;
        logic        rdy;
        logic [15:0] pc;
        logic [15:0] rd;
        logic        ereq;
        logic [15:0] eaddr;
        logic [15:0] eins;
        logic        evld;
        logic        estall;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic fr, input logic fl, input logic ack, input logic rdy,
        input logic [15:0] p, input logic [15:0] rd,
        input logic ereq, input logic [15:0] eaddr, input logic [15:0] eins,
        input logic evld, input logic estall);
        vec_t v;
        v.fr = fr; v.fl = fl; v.ack = ack; v.rdy = rdy;
        v.pc = p; v.rd = rd;
        v.ereq = ereq; v.eaddr = eaddr; v.eins = eins;
        v.evld = evld; v.estall = estall;
        return v;
    endfunction

    // {mem_req, mem_addr, ins, ins_valid, stall, fetch_err}
    function automatic logic [35:0] obs();
        return {mem_req, mem_addr, ins, ins_valid, stall, fetch_err};
    endfunction

    task automatic check(input string name, input logic [35:0] exp);
        logic [35:0] got;
        got = obs();
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got req=%b addr=%h ins=%h vld=%b stall=%b err=%b, want req=%b addr=%h ins=%h vld=%b stall=%b err=%b",
                     name, got[35], got[34:19], got[18:3], got[2], got[1], got[0],
                     exp[35], exp[34:19], exp[18:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        fetch_req = 1'b0; flush = 1'b0; mem_ack = 1'b0;
        ins_ready = 1'b0; mem_rdata = 16'h0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        pc = 16'h0;
        idle_in();

        //            fr fl ak rd pc       rdata    | req addr     ins      vld stall
        tbl[0]  = mk(1, 0, 0, 0, 16'h0010, 16'h0000, 1, 16'h0010, 16'h0000, 0, 1);
        tbl[1]  = mk(0, 0, 0, 0, 16'h0010, 16'h0000, 1, 16'h0010, 16'h0000, 0, 1);
        tbl[2]  = mk(0, 0, 0, 0, 16'h0010, 16'h0000, 1, 16'h0010, 16'h0000, 0, 1);
        tbl[3]  = mk(0, 0, 1, 0, 16'h0010, 16'hA5C3, 0, 16'h0010, 16'hA5C3, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 16'h0010, 16'h0000, 0, 16'h0010, 16'hA5C3, 1, 0);
        tbl[5]  = mk(1, 0, 0, 1, 16'h0011, 16'h0000, 1, 16'h0011, 16'hA5C3, 0, 1);
        tbl[6]  = mk(0, 0, 1, 0, 16'h0011, 16'h1234, 0, 16'h0011, 16'h1234, 1, 0);
        tbl[7]  = mk(0, 0, 0, 1, 16'h0011, 16'h0000, 0, 16'h0011, 16'h1234, 0, 1);
        tbl[8]  = mk(1, 0, 0, 0, 16'h0020, 16'h0000, 1, 16'h0020, 16'h1234, 0, 1);
        tbl[9]  = mk(0, 1, 0, 0, 16'h0020, 16'h0000, 1, 16'h0020, 16'h1234, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 16'h0020, 16'h0000, 1, 16'h0020, 16'h1234, 0, 1);
        tbl[11] = mk(0, 0, 1, 0, 16'h0020, 16'hDEAD, 0, 16'h0020, 16'h1234, 0, 1);
        tbl[12] = mk(1, 0, 0, 0, 16'h0040, 16'h0000, 1, 16'h0040, 16'h1234, 0, 1);
        tbl[13] = mk(0, 0, 1, 0, 16'h0040, 16'hBEEF, 0, 16'h0040, 16'hBEEF, 1, 0);
        tbl[14] = mk(1, 1, 0, 1, 16'h0050, 16'h0000, 0, 16'h0040, 16'hBEEF, 0, 1);
        tbl[15] = mk(1, 1, 0, 0, 16'h0060, 16'h0000, 0, 16'h0040, 16'hBEEF, 0, 1);
        tbl[16] = mk(1, 0, 0, 0, 16'h0060, 16'h0000, 1, 16'h0060, 16'hBEEF, 0, 1);
        tbl[17] = mk(0, 1, 1, 0, 16'h0060, 16'hCAFE, 0, 16'h0060, 16'hBEEF, 0, 1);
        tbl[18] = mk(0, 0, 1, 0, 16'h0060, 16'h1111, 0, 16'h0060, 16'hBEEF, 0, 1);
        tbl[19] = mk(1, 0, 0, 0, 16'hFFFF, 16'h0000, 1, 16'hFFFF, 16'hBEEF, 0, 1);
        tbl[20] = mk(1, 0, 1, 0, 16'h0000, 16'h5A5A, 0, 16'hFFFF, 16'h5A5A, 1, 0);
        tbl[21] = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h5A5A, 1, 0);
        tbl[22] = mk(1, 0, 1, 1, 16'h0002, 16'h7777, 1, 16'h0002, 16'h5A5A, 0, 1);
        tbl[23] = mk(0, 0, 0, 0, 16'h0003, 16'h0000, 1, 16'h0002, 16'h5A5A, 0, 1);

        repeat (2) step();
        check("reset_state", {1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0});
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            fetch_req = tbl[i].fr;
            flush     = tbl[i].fl;
            mem_ack   = tbl[i].ack;
            ins_ready = tbl[i].rdy;
            pc        = tbl[i].pc;
            mem_rdata = tbl[i].rd;
            step();
            check($sformatf("vec%0d", i),
                  {tbl[i].ereq, tbl[i].eaddr, tbl[i].eins, tbl[i].evld, tbl[i].estall, 1'b0});
        end

        // Async reset while a request is outstanding, then a stale ack
        idle_in();
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0});
        mem_ack = 1'b1;
        mem_rdata = 16'h9999;
        step();
        rst = 1'b0;
        step();
        check("ack_after_rst", {1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0});
        idle_in();

`ifdef FETCH_TIMEOUT_EN
        fetch_req = 1'b1; pc = 16'h0070;
        step();
        fetch_req = 1'b0;
        repeat (7) step();
        check("wdog_before_limit", {1'b1, 16'h0070, 16'h0, 1'b0, 1'b1, 1'b0});
        step();
        check("wdog_timeout", {1'b0, 16'h0070, 16'h0, 1'b0, 1'b1, 1'b1});
        fetch_req = 1'b1; pc = 16'h0080;
        repeat (2) step();
        check("err_blocks_fetch", {1'b0, 16'h0070, 16'h0, 1'b0, 1'b1, 1'b1});
        idle_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("err_cleared", {1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0});
        fetch_req = 1'b1; pc = 16'h0090;
        step();
        fetch_req = 1'b0;
        repeat (7) step();
        mem_ack = 1'b1; mem_rdata = 16'h4B4B;
        step();
        check("ack_at_limit", {1'b0, 16'h0090, 16'h4B4B, 1'b1, 1'b0, 1'b0});
`else
        fetch_req = 1'b1; pc = 16'h0070;
        step();
        fetch_req = 1'b0;
        repeat (20) step();
        check("no_timeout", {1'b1, 16'h0070, 16'h0, 1'b0, 1'b1, 1'b0});
        mem_ack = 1'b1; mem_rdata = 16'h3C3C;
        step();
        check("late_ack", {1'b0, 16'h0070, 16'h3C3C, 1'b1, 1'b0, 1'b0});
`endif
        idle_in();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
